// File: rtl/init_sequencer_pkg.sv
// Shared definitions for the init sequencer: FSM state encoding, phase codes,
// reset-vector width and the per-phase acknowledge masks.
package init_sequencer_pkg;

  localparam int RV_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ASSERT = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  // Sub-blocks that must acknowledge each phase, following the system reset map.
  localparam logic [RV_W-1:0] MASK_PH0 = 6'b000001;
  localparam logic [RV_W-1:0] MASK_PH1 = 6'b001110;
  localparam logic [RV_W-1:0] MASK_PH2 = 6'b000110;
  localparam logic [RV_W-1:0] MASK_PH3 = 6'b111000;

  function automatic logic [RV_W-1:0] phase_mask(input logic [1:0] ph);
    logic [RV_W-1:0] m;
    case (ph)
      PH_0:    m = MASK_PH0;
      PH_1:    m = MASK_PH1;
      PH_2:    m = MASK_PH2;
      default: m = MASK_PH3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/init_sequencer_if.sv
// Control/status bundle between the start logic, the sub-block acknowledges
// and the reset mux. The slave side is the sequencer itself.
//
// Handshake: start is a single-cycle request sampled on a rising clk edge; it
// is honoured only while the sequencer is idle, done or failed. done is a
// level per sub-block, sampled only while the sequencer waits on a phase.
// All outputs are registered.
interface init_sequencer_if;
  import init_sequencer_pkg::*;

  logic            start;
  logic [RV_W-1:0] done;
  logic [1:0]      init_sel;
  logic            init_active;
  logic            init_done;
  logic            init_err;
  logic [1:0]      err_phase;
  state_e          dbg_state;

  modport slave (
    input  start, done,
    output init_sel, init_active, init_done, init_err, err_phase, dbg_state
  );

  modport master (
    output start, done,
    input  init_sel, init_active, init_done, init_err, err_phase, dbg_state
  );

endinterface

// File: rtl/init_sequencer_phase_timer.sv
// Loadable up-counter with a terminal-count flag. clr reloads zero and has
// priority over counting; tc is high on the TERM-th enabled cycle.
module init_sequencer_phase_timer #(
  parameter int TERM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TERM + 1);
  localparam logic [W-1:0] TC_VAL = W'(TERM - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on clear, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/init_sequencer.sv
// Power-up / re-init sequencer. Walks phases 0..3: each phase drives its code
// on init_sel with init_active high for HOLD_CYCLES cycles, then waits up to
// TIMEOUT cycles for the phase's sub-blocks to acknowledge on done.
module init_sequencer
  import init_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  init_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;

  logic       hold_tc;
  logic       wait_tc;
  logic       state_change;
  logic       phase_ok;

  logic [1:0] init_sel_q, init_sel_d;
  logic       init_active_q, init_active_d;
  logic       init_done_q, init_done_d;
  logic       init_err_q, init_err_d;
  logic [1:0] err_phase_q, err_phase_d;

  // Both timers restart whenever the FSM enters a new state.
  assign state_change = (state_d != state_q);
  assign phase_ok     = ((bus.done & phase_mask(phase_q)) == phase_mask(phase_q));

  init_sequencer_phase_timer #(.TERM(HOLD_CYCLES)) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_change),
    .en    (state_q == ST_ASSERT),
    .tc    (hold_tc)
  );

  init_sequencer_phase_timer #(.TERM(TIMEOUT)) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_change),
    .en    (state_q == ST_WAIT),
    .tc    (wait_tc)
  );

  // Next state and phase; an acknowledge in the last WAIT cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.start) begin
          state_d = ST_ASSERT;
          phase_d = PH_0;
        end
      end
      ST_ASSERT: begin
        if (hold_tc) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (phase_ok) begin
          if (phase_q == PH_3) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ASSERT;
            phase_d = phase_q + 2'd1;
          end
        end else if (wait_tc) begin
          state_d = ST_FAIL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = PH_0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    init_sel_d    = 2'd0;
    init_active_d = 1'b0;
    init_done_d   = 1'b0;
    init_err_d    = 1'b0;
    err_phase_d   = 2'd0;
    case (state_d)
      ST_ASSERT: begin
        init_sel_d    = phase_d;
        init_active_d = 1'b1;
      end
      ST_WAIT: begin
        init_sel_d = phase_d;
      end
      ST_DONE: begin
        init_done_d = 1'b1;
      end
      ST_FAIL: begin
        init_err_d  = 1'b1;
        err_phase_d = phase_d;
      end
      default: begin
        init_sel_d = 2'd0;
      end
    endcase
  end

  // State, phase and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_0;
      init_sel_q    <= 2'd0;
      init_active_q <= 1'b0;
      init_done_q   <= 1'b0;
      init_err_q    <= 1'b0;
      err_phase_q   <= 2'd0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      init_sel_q    <= init_sel_d;
      init_active_q <= init_active_d;
      init_done_q   <= init_done_d;
      init_err_q    <= init_err_d;
      err_phase_q   <= err_phase_d;
    end
  end

  assign bus.init_sel    = init_sel_q;
  assign bus.init_active = init_active_q;
  assign bus.init_done   = init_done_q;
  assign bus.init_err    = init_err_q;
  assign bus.err_phase   = err_phase_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer with HOLD_CYCLES=4, TIMEOUT=16.
// Cycle c is the clock period after the c-th rising edge following the one
// that samples start; inputs are driven and outputs sampled 1ns after posedge.
module tb_init_sequencer;
  import init_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  init_sequencer_if bus ();

  init_sequencer #(
    .HOLD_CYCLES (4),
    .TIMEOUT     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] sel, input logic act,
                               input logic dn, input logic err, input logic [1:0] eph);
    check({tag, "_sel"},    32'(bus.init_sel),    32'(sel));
    check({tag, "_active"}, 32'(bus.init_active), 32'(act));
    check({tag, "_done"},   32'(bus.init_done),   32'(dn));
    check({tag, "_err"},    32'(bus.init_err),    32'(err));
    check({tag, "_ephase"}, 32'(bus.err_phase),   32'(eph));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Raise start for one sampled edge; returns observing cycle 1.
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int  ph;
    logic exp_act;
    logic [1:0] exp_sel;
    n_compared   = 0;
    n_mismatched = 0;
    bus.done     = '0;

    // Reset state
    do_reset();
    check_outputs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // 1: all acknowledges present, full sequence in 21 cycles
    bus.done = 6'b111111;
    pulse_start();
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) tick();
      if (c <= 20) begin
        ph      = (c - 1) / 5;
        exp_act = ((c - 1) % 5) != 4;
        exp_sel = 2'(ph);
        check_outputs($sformatf("s1_c%0d", c), exp_sel, exp_act, 1'b0, 1'b0, 2'd0);
      end else begin
        check_outputs($sformatf("s1_c%0d", c), 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
      end
    end

    // 2: no acknowledge at all, phase 0 times out after 16 WAIT cycles
    do_reset();
    bus.done = 6'b000000;
    pulse_start();
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) tick();
      if (c >= 5 && c <= 20) begin
        check($sformatf("s2_state_c%0d", c), 32'(bus.dbg_state), 32'(ST_WAIT));
        check_outputs($sformatf("s2_c%0d", c), 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      end
    end
    check_outputs("s2_fail", 2'd0, 1'b0, 1'b0, 1'b1, 2'd0);

    // 3: phase 0 acknowledged, phase 1 only partially (001100) -> fail in phase 1
    do_reset();
    bus.done = 6'b000001;
    pulse_start();
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) tick();
      if (c == 6) bus.done = 6'b001100;
      exp_sel = (c <= 5) ? 2'd0 : (c <= 25) ? 2'd1 : 2'd0;
      check($sformatf("s3_sel_c%0d", c), 32'(bus.init_sel), 32'(exp_sel));
      if (c == 10) check("s3_active_wait", 32'(bus.init_active), 32'd0);
      if (c == 25) check("s3_err_early", 32'(bus.init_err), 32'd0);
    end
    check_outputs("s3_fail", 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);

    // 6 (from FAIL): restart clears error, mid-sequence start pulses ignored
    bus.done = 6'b000000;
    pulse_start();
    check_outputs("s6_restart", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int c = 2; c <= 21; c++) begin
      tick();
      bus.start = (c == 2 || c == 7) ? 1'b1 : 1'b0;
      exp_act = (c <= 4);
      check($sformatf("s6_active_c%0d", c), 32'(bus.init_active), 32'(exp_act));
      if (c <= 20) check($sformatf("s6_err_c%0d", c), 32'(bus.init_err), 32'd0);
    end
    bus.start = 1'b0;
    check_outputs("s6_fail", 2'd0, 1'b0, 1'b0, 1'b1, 2'd0);

    // 4: done[0] arrives on the 16th WAIT cycle -> success beats timeout
    do_reset();
    bus.done = 6'b000000;
    pulse_start();
    for (int c = 2; c <= 21; c++) begin
      tick();
      if (c == 20) begin
        check_outputs("s4_c20", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.done = 6'b000001;
      end
    end
    check_outputs("s4_c21", 2'd1, 1'b1, 1'b0, 1'b0, 2'd0);

    // 5: reset pulse in the middle of phase 2 ASSERT
    do_reset();
    bus.done = 6'b111111;
    pulse_start();
    for (int c = 2; c <= 12; c++) tick();
    check_outputs("s5_ph2", 2'd2, 1'b1, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outputs("s5_rst", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("s5_rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    for (int c = 0; c < 25; c++) begin
      tick();
      if (c % 6 == 5) check_outputs($sformatf("s5_idle_%0d", c), 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
